rtl_divider: RTL and testbench

Sequential unsigned integer divider that inverts the registered `rtl_multiplier` datapath. It divides an N-bit dividend by a D-bit divisor and returns the quotient and remainder. It uses a restoring algorithm that retires one quotient bit per clock, behind a start/ready/valid handshake. It sits beside the multiplier in the PL arithmetic IP, so a product can be checked or decomposed without a combinational divider in the timing path.

---
 rtl/rtl_divider.sv | 143 ++++++++++++++
 tb/tb_rtl_divider.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtl_divider.sv
// rtl_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: start/ready in, valid pulse out; quotient/remainder are registered.
// Optional build macro RTL_DIVIDER_DIV0_EN: a zero divisor bypasses BUSY and
// raises div_by_zero alongside valid.
module rtl_divider #(
  parameter int unsigned N = 32,
  parameter int unsigned D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder
`ifdef RTL_DIVIDER_DIV0_EN
  ,
  output logic         div_by_zero
`endif
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  // Dividend register doubles as the quotient register: dividend bits leave
  // from the MSB while quotient bits enter at the LSB.
  logic [N-1:0]   r_dq;
  logic [D-1:0]   r_dvsr;
  logic [D:0]     r_rem;
  logic [CW-1:0]  r_cnt;

  logic [D:0]     w_shift;
  logic [D:0]     w_diff;
  logic [D:0]     w_rem_next;
  logic           w_qbit;
  logic           w_accept;
  logic           w_last;
`ifdef RTL_DIVIDER_DIV0_EN
  logic           w_div0_in;
  assign w_div0_in = (divisor == '0);
`endif

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_shift    = (r_rem << 1) | {{D{1'b0}}, r_dq[N-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_qbit     = (w_shift >= {1'b0, r_dvsr});
  assign w_rem_next = w_qbit ? w_diff : w_shift;

  assign ready = (r_state == S_IDLE);
  assign valid = (r_state == S_DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef RTL_DIVIDER_DIV0_EN
          w_state_next = w_div0_in ? S_DONE : S_BUSY;
`else
          w_state_next = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, restoring iteration and result load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dq      <= '0;
      r_dvsr    <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef RTL_DIVIDER_DIV0_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_dq   <= dividend;
        r_dvsr <= divisor;
        r_rem  <= '0;
        r_cnt  <= CW'(N - 1);
`ifdef RTL_DIVIDER_DIV0_EN
        if (w_div0_in) begin
          quotient    <= '1;
          remainder   <= dividend[D-1:0];
          div_by_zero <= 1'b1;
        end
`endif
      end else if (r_state == S_BUSY) begin
        r_dq  <= {r_dq[N-2:0], w_qbit};
        r_rem <= w_rem_next;
        if (!w_last) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          // A zero divisor subtracts nothing, so the partial remainder has
          // simply accumulated the low dividend bits; only the quotient
          // needs forcing.
          quotient  <= (r_dvsr == '0) ? '1 : {r_dq[N-2:0], w_qbit};
          remainder <= w_rem_next[D-1:0];
`ifdef RTL_DIVIDER_DIV0_EN
          div_by_zero <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rtl_divider.sv
// tb_rtl_divider: directed table vectors plus hand-written handshake sequences.
module tb_rtl_divider;
  localparam int unsigned N = 32;
  localparam int unsigned D = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [D-1:0] divisor;
  logic         ready;
  logic         valid;
  logic [N-1:0] quotient;
  logic [D-1:0] remainder;
`ifdef RTL_DIVIDER_DIV0_EN
  logic         div_by_zero;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rtl_divider #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef RTL_DIVIDER_DIV0_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and waits (bounded) for its valid pulse.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        output logic [31:0] q, output logic [15:0] r,
                        output int lat, output bit rdy_seen);
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!valid && lat < int'(N) + 8) begin
      if (ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    if (ready) rdy_seen = 1'b1;
    q = quotient;
    r = remainder;
  endtask

  logic [31:0] q, ea;
  logic [15:0] r, eb;
  logic [31:0] eq;
  logic [15:0] er;
  int          lat, w, nvalid, prev_cyc, exp_lat;
  bit          rdy_seen;

  initial begin
    vecs[0]  = '{32'd100,        16'd7,      32'd14,         16'd2};
    vecs[1]  = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'h0000};
    vecs[2]  = '{32'hFFFF_FFFF,  16'h0001,   32'hFFFF_FFFF,  16'h0000};
    vecs[3]  = '{32'h1234_5678,  16'h0000,   32'hFFFF_FFFF,  16'h5678};
    vecs[4]  = '{32'd81,         16'd9,      32'd9,          16'd0};
    vecs[5]  = '{32'd0,          16'd5,      32'd0,          16'd0};
    vecs[6]  = '{32'd5,          16'd10,     32'd0,          16'd5};
    vecs[7]  = '{32'd1000,       16'd3,      32'd333,        16'd1};
    vecs[8]  = '{32'h0001_0000,  16'h0100,   32'h0000_0100,  16'h0000};
    vecs[9]  = '{32'hFFFF_FFFF,  16'h8000,   32'h0001_FFFF,  16'h7FFF};
    vecs[10] = '{32'd12345,      16'd100,    32'd123,        16'd45};
    vecs[11] = '{32'h0000_0000,  16'h0000,   32'hFFFF_FFFF,  16'h0000};

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    chk("reset_ready", ready, 1);
    chk("reset_valid", valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
`ifdef RTL_DIVIDER_DIV0_EN
    chk("reset_div0", div_by_zero, 0);
`endif
    rst = 1'b0;
    tick();

    // Table-driven vectors; the last entry leaves a non-zero quotient for the
    // reset-abort sequence to clear.
    for (int i = 0; i < 12; i++) begin
      int k;
      k = (i == 11) ? 10 : i;
      if (i == 11) k = 11;
      run_op(vecs[k].a, vecs[k].b, q, r, lat, rdy_seen);
      exp_lat = int'(N);
`ifdef RTL_DIVIDER_DIV0_EN
      if (vecs[k].b == 16'h0) exp_lat = 0;
      chk($sformatf("vec%0d_div0", k), div_by_zero, (vecs[k].b == 16'h0) ? 1 : 0);
`endif
      chk($sformatf("vec%0d_quotient", k), q, vecs[k].q);
      chk($sformatf("vec%0d_remainder", k), r, vecs[k].r);
      chk($sformatf("vec%0d_latency", k), lat, exp_lat);
      chk($sformatf("vec%0d_ready_low_while_busy", k), rdy_seen, 0);
      tick();
      chk($sformatf("vec%0d_valid_one_cycle", k), valid, 0);
      chk($sformatf("vec%0d_ready_back", k), ready, 1);
    end

    // Make the held result non-zero before the abort test.
    run_op(32'd100, 16'd7, q, r, lat, rdy_seen);
    tick();

    // start during BUSY must be ignored.
    start = 1'b1;
    dividend = 32'd1000;
    divisor = 16'd3;
    tick();
    dividend = 32'd50;
    divisor = 16'd5;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    w = 5;
    while (!valid && w < int'(N) + 8) begin
      tick();
      w++;
    end
    chk("busy_start_latency", w, N);
    chk("busy_start_quotient", quotient, 333);
    chk("busy_start_remainder", remainder, 1);
    nvalid = 0;
    for (int i = 0; i < int'(N) + 4; i++) begin
      tick();
      if (valid) nvalid++;
    end
    chk("busy_start_single_result", nvalid, 0);

    // Reset mid-BUSY aborts without a valid pulse.
    start = 1'b1;
    dividend = 32'hDEAD_BEEF;
    divisor = 16'h001D;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_valid", valid, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    tick();
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < int'(N) + 4; i++) begin
      tick();
      if (valid) nvalid++;
    end
    chk("abort_no_valid", nvalid, 0);
    chk("abort_idle_ready", ready, 1);
    run_op(32'd81, 16'd9, q, r, lat, rdy_seen);
    chk("after_abort_quotient", q, 9);
    chk("after_abort_remainder", r, 0);
    chk("after_abort_latency", lat, N);
    tick();

    // start held high: back-to-back operations at N+2 spacing.
    start = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      ea = $urandom;
      eb = 16'($urandom);
      if (i % 5 == 0) eb = 16'($urandom_range(1, 15));
      if (i % 3 == 0) ea = ea >> $urandom_range(0, 31);
      if (i % 17 == 0) eb = 16'h0;
`ifdef RTL_DIVIDER_DIV0_EN
      if (eb == 16'h0) eb = 16'h1;
`endif
      if (eb == 16'h0) begin
        eq = 32'hFFFF_FFFF;
        er = ea[15:0];
      end else begin
        eq = ea / {16'h0, eb};
        er = 16'(ea % {16'h0, eb});
      end
      dividend = ea;
      divisor = eb;
      chk("b2b_ready", ready, 1);
      tick();
      w = 0;
      while (!valid && w < int'(N) + 8) begin
        tick();
        w++;
      end
      chk($sformatf("b2b%0d_quotient a=%0h b=%0h", i, ea, eb), quotient, eq);
      chk($sformatf("b2b%0d_remainder a=%0h b=%0h", i, ea, eb), remainder, er);
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), cyc - prev_cyc, N + 2);
      prev_cyc = cyc;
      tick();
    end
    start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
